// File: rtl/ip4_rtl_pkg.sv
// Shared ip4 RTL types and constants: AXI widths, fixed AXI field encodings,
// and the EIF bridge state/request types.
package ip4_rtl_pkg;

  localparam int WID_AXI_ADDR   = 32;
  localparam int WID_AXI_DATA   = 64;
  localparam int BYTES_AXI_DATA = WID_AXI_DATA / 8;
  localparam int WID_AXI_ID     = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_DATA  = 3'($clog2(BYTES_AXI_DATA));

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [WID_AXI_ADDR-1:0] AXI_ADDR_LSB_MASK = WID_AXI_ADDR'(BYTES_AXI_DATA - 1);

  typedef enum logic [2:0] {
    EIF_IDLE,
    EIF_AW,
    EIF_W,
    EIF_B,
    EIF_AR,
    EIF_R
  } eif_state_e;

  typedef struct packed {
    logic                    we;
    logic [WID_AXI_ADDR-1:0] addr;
    logic [3:0]              len;
    logic [WID_AXI_ID-1:0]   id;
  } eif_req_t;

  // Bursts always use full-width beats, so the start address is beat aligned.
  function automatic logic [WID_AXI_ADDR-1:0] eif_align_addr(input logic [WID_AXI_ADDR-1:0] a);
    return a & ~AXI_ADDR_LSB_MASK;
  endfunction

endpackage

// File: rtl/ip4_axi_if.sv
// AXI3 bundle used on the ip4 master/slave ports.
interface ip4_axi_if;
  import ip4_rtl_pkg::*;

  logic                      aclk;

  logic [WID_AXI_ID-1:0]     awid;
  logic [WID_AXI_ADDR-1:0]   awaddr;
  logic [3:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic [1:0]                awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;

  logic [WID_AXI_ID-1:0]     wid;
  logic [WID_AXI_DATA-1:0]   wdata;
  logic [BYTES_AXI_DATA-1:0] wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;

  logic [WID_AXI_ID-1:0]     bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [WID_AXI_ID-1:0]     arid;
  logic [WID_AXI_ADDR-1:0]   araddr;
  logic [3:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic [1:0]                arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;

  logic [WID_AXI_ID-1:0]     rid;
  logic [WID_AXI_DATA-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport mst (
    output aclk,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slv (
    input  aclk,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/ip4_eif_wdog.sv
// Loadable down-counter watchdog: expired_o pulses on the decrement that
// reaches zero; the count then rests at zero until reloaded.
module ip4_eif_wdog #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !load_i && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/ip4_eif_axi_bridge.sv
// EIF stage: turns one DSE memory request at a time into an AXI3 INCR burst,
// streaming write beats out and read beats / write responses back.
module ip4_eif_axi_bridge
  import ip4_rtl_pkg::*;
#(
  parameter int unsigned           TIMEOUT = 1024,
  parameter logic [WID_AXI_ID-1:0] AXI_ID  = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [WID_AXI_ADDR-1:0]   req_addr,
  input  logic [3:0]                req_len,
  input  logic [WID_AXI_ID-1:0]     req_id,

  input  logic                      wd_valid,
  output logic                      wd_ready,
  input  logic [WID_AXI_DATA-1:0]   wd_data,
  input  logic [BYTES_AXI_DATA-1:0] wd_strb,

  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [WID_AXI_DATA-1:0]   rd_data,
  output logic                      rd_last,
  output logic [1:0]                rd_resp,

  output logic                      wr_done,
  output logic [1:0]                wr_resp,
  output logic                      err_len,
  output logic                      err_tmo,

  ip4_axi_if.mst                    axi
);

  localparam int WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  eif_state_e state_q, state_d;
  eif_req_t   req_q, req_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_len_q, err_len_d;
  logic       err_tmo_q, err_tmo_d;
  logic       wr_done_q, wr_done_d;
  logic [1:0] wr_resp_q, wr_resp_d;

  logic in_w, in_r;
  logic w_hs, b_hs, r_hs;
  logic wdog_active, wdog_expired;

  assign in_w = (state_q == EIF_W);
  assign in_r = (state_q == EIF_R);
  assign w_hs = in_w && wd_valid && axi.wready;
  assign b_hs = (state_q == EIF_B) && axi.bvalid;
  assign r_hs = in_r && axi.rvalid && rd_ready;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    err_len_d = err_len_q;
    err_tmo_d = err_tmo_q | wdog_expired;
    wr_done_d = 1'b0;
    wr_resp_d = wr_resp_q;

    unique case (state_q)
      EIF_IDLE: begin
        if (req_valid) begin
          req_d.we   = req_we;
          req_d.addr = eif_align_addr(req_addr);
          req_d.len  = req_len;
          req_d.id   = req_id;
          state_d    = req_we ? EIF_AW : EIF_AR;
        end
      end
      EIF_AW: begin
        if (axi.awready) begin
          state_d = EIF_W;
          cnt_d   = '0;
        end
      end
      EIF_W: begin
        if (w_hs) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == req_q.len) state_d = EIF_B;
        end
      end
      EIF_B: begin
        if (b_hs) begin
          wr_done_d = 1'b1;
          wr_resp_d = axi.bresp;
          state_d   = EIF_IDLE;
        end
      end
      EIF_AR: begin
        if (axi.arready) begin
          state_d = EIF_R;
          cnt_d   = '0;
        end
      end
      EIF_R: begin
        if (r_hs) begin
          cnt_d = cnt_q + 4'd1;
          // Slave's rlast must coincide exactly with the final requested beat.
          if (axi.rlast != (cnt_q == req_q.len)) err_len_d = 1'b1;
          if (axi.rlast) state_d = EIF_IDLE;
        end
      end
      default: state_d = EIF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EIF_IDLE;
      req_q     <= '{we: 1'b0, addr: '0, len: '0, id: AXI_ID};
      cnt_q     <= '0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      wr_done_q <= 1'b0;
      wr_resp_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      wr_done_q <= wr_done_d;
      wr_resp_q <= wr_resp_d;
    end
  end

  // Held loaded outside B/R so each wait starts from a full TIMEOUT count.
  assign wdog_active = (TIMEOUT != 0) && ((state_q == EIF_B) || (state_q == EIF_R));

  ip4_eif_wdog #(
    .WIDTH (WDOG_W)
  ) u_wdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (!wdog_active || b_hs || r_hs),
    .load_val_i (WDOG_W'(TIMEOUT)),
    .en_i       (wdog_active),
    .expired_o  (wdog_expired)
  );

  assign req_ready   = (state_q == EIF_IDLE);

  assign axi.aclk    = clk;

  assign axi.awid    = req_q.id;
  assign axi.awaddr  = req_q.addr;
  assign axi.awlen   = req_q.len;
  assign axi.awsize  = AXI_SIZE_DATA;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = (state_q == EIF_AW);

  assign axi.wid     = req_q.id;
  assign axi.wdata   = in_w ? wd_data : '0;
  assign axi.wstrb   = in_w ? wd_strb : '0;
  assign axi.wlast   = in_w && (cnt_q == req_q.len);
  assign axi.wvalid  = in_w && wd_valid;
  assign wd_ready    = in_w && axi.wready;

  assign axi.bready  = (state_q == EIF_B);

  assign axi.arid    = req_q.id;
  assign axi.araddr  = req_q.addr;
  assign axi.arlen   = req_q.len;
  assign axi.arsize  = AXI_SIZE_DATA;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = (state_q == EIF_AR);

  assign axi.rready  = in_r && rd_ready;
  assign rd_valid    = in_r && axi.rvalid;
  assign rd_data     = in_r ? axi.rdata : '0;
  assign rd_resp     = in_r ? axi.rresp : '0;
  assign rd_last     = in_r && axi.rlast;

  assign wr_done     = wr_done_q;
  assign wr_resp     = wr_resp_q;
  assign err_len     = err_len_q;
  assign err_tmo     = err_tmo_q;

  // IDs are fixed per request and the direction lives in the state, so these go unread.
  logic unused_ok;
  assign unused_ok = ^{axi.bid, axi.rid, req_q.we};

endmodule

// File: tb/tb_ip4_eif_axi_bridge.sv
// Directed bench for ip4_eif_axi_bridge: a vector table of bursts played
// against a scripted AXI slave, plus hand-written reset-mid-burst sequence.
module tb_ip4_eif_axi_bridge;
  import ip4_rtl_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic                      req_we = 1'b0;
  logic [WID_AXI_ADDR-1:0]   req_addr = '0;
  logic [3:0]                req_len = '0;
  logic [WID_AXI_ID-1:0]     req_id = '0;
  logic                      wd_valid = 1'b0;
  logic                      wd_ready;
  logic [WID_AXI_DATA-1:0]   wd_data = '0;
  logic [BYTES_AXI_DATA-1:0] wd_strb = '0;
  logic                      rd_valid;
  logic                      rd_ready = 1'b0;
  logic [WID_AXI_DATA-1:0]   rd_data;
  logic                      rd_last;
  logic [1:0]                rd_resp;
  logic                      wr_done;
  logic [1:0]                wr_resp;
  logic                      err_len;
  logic                      err_tmo;

  ip4_axi_if axi();

  ip4_eif_axi_bridge #(.TIMEOUT(TMO), .AXI_ID('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_id(req_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .rd_resp(rd_resp),
    .wr_done(wr_done), .wr_resp(wr_resp), .err_len(err_len), .err_tmo(err_tmo),
    .axi(axi)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_tmo = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WID_AXI_DATA-1:0] wdat(input int n, input int b);
    return 64'hA5A5_0000_0000_0000 | (64'(n) << 16) | 64'(b);
  endfunction

  function automatic logic [WID_AXI_DATA-1:0] rdat(input int n, input int b);
    return 64'h5A5A_0000_0000_0000 | (64'(n) << 24) | 64'(b * 3 + 1);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
    int          addr_dly;   // cycles before awready/arready
    int          resp_dly;   // B-state cycles before bvalid (0: raised with the wlast beat)
    logic [1:0]  resp;
    int          mode;       // 1: toggle wd_valid/wready or rd_ready
    int          bad_last;   // read beat index carrying an early rlast, -1 for none
    logic [31:0] exp_addr;
    logic        exp_err_len;
  } vec_t;

  vec_t vecs[9];

  task automatic idle_slave();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0; axi.bid = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    axi.rlast = 1'b0; axi.rid = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_awvalid"}, axi.awvalid, 0);
    chk({tag, "_wvalid"},  axi.wvalid, 0);
    chk({tag, "_arvalid"}, axi.arvalid, 0);
    chk({tag, "_bready"},  axi.bready, 0);
    chk({tag, "_rready"},  axi.rready, 0);
    chk({tag, "_wd_ready"}, wd_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_wr_done"}, wr_done, 0);
    chk({tag, "_err_len"}, err_len, 0);
    chk({tag, "_err_tmo"}, err_tmo, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_awaddr"}, axi.awaddr, 0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int   t;
    int   beat;
    logic last;
    logic hs;
    assert ((int'(v.addr[11:0]) & ~(BYTES_AXI_DATA - 1)) + (int'(v.len) + 1) * BYTES_AXI_DATA <= 4096)
      else $error("vector %0d crosses a 4 KB boundary", n);

    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_len = v.len; req_id = v.id;
    #1 chk("req_ready", req_ready, 1);

    t = 0;
    forever begin
      @(negedge clk);
      req_valid = 1'b0;
      if (v.we) axi.awready = (t >= v.addr_dly);
      else      axi.arready = (t >= v.addr_dly);
      #1;
      chk("req_held_off", req_ready, 0);
      if (v.we) begin
        chk("awvalid", axi.awvalid, 1);  chk("awaddr", axi.awaddr, v.exp_addr);
        chk("awlen", axi.awlen, v.len);  chk("awsize", axi.awsize, 3);
        chk("awburst", axi.awburst, 1);  chk("awid", axi.awid, v.id);
        chk("awlock_cache_prot", {axi.awlock, axi.awcache, axi.awprot}, 0);
        chk("arvalid_in_aw", axi.arvalid, 0);
      end else begin
        chk("arvalid", axi.arvalid, 1);  chk("araddr", axi.araddr, v.exp_addr);
        chk("arlen", axi.arlen, v.len);  chk("arsize", axi.arsize, 3);
        chk("arburst", axi.arburst, 1);  chk("arid", axi.arid, v.id);
        chk("arlock_cache_prot", {axi.arlock, axi.arcache, axi.arprot}, 0);
        chk("awvalid_in_ar", axi.awvalid, 0);
      end
      if (t >= v.addr_dly) break;
      t++;
    end

    beat = 0;
    t = 0;
    if (v.we) begin
      forever begin
        @(negedge clk);
        axi.awready = 1'b0;
        wd_valid   = (v.mode == 0) || (t % 2 == 0);
        axi.wready = (v.mode == 0) || (t % 3 != 2);
        wd_data = wdat(n, beat);
        wd_strb = 8'(beat * 37 + 1);
        if (v.resp_dly == 0 && beat == int'(v.len)) begin
          axi.bvalid = 1'b1; axi.bresp = v.resp;
        end
        #1;
        chk("wvalid", axi.wvalid, wd_valid);
        chk("wd_ready", wd_ready, axi.wready);
        chk("bready_in_w", axi.bready, 0);
        if (wd_valid) begin
          chk("wdata", axi.wdata, wd_data);
          chk("wstrb", axi.wstrb, wd_strb);
          chk("wlast", axi.wlast, beat == int'(v.len));
          chk("wid", axi.wid, v.id);
        end
        hs = wd_valid && axi.wready;
        t++;
        if (hs) begin
          if (beat == int'(v.len)) break;
          beat++;
        end
      end

      t = 0;
      forever begin
        @(negedge clk);
        wd_valid = 1'b0; axi.wready = 1'b0;
        axi.bvalid = (t >= v.resp_dly); axi.bresp = v.resp;
        #1;
        chk("bready", axi.bready, 1);
        chk("wr_done_early", wr_done, 0);
        chk("err_tmo_in_b", err_tmo, exp_tmo || (t >= TMO));
        if (axi.bvalid) break;
        t++;
      end
      if (t >= TMO) exp_tmo = 1'b1;
      @(negedge clk);
      axi.bvalid = 1'b0;
      #1;
      chk("wr_done", wr_done, 1);
      chk("wr_resp", wr_resp, v.resp);
      chk("req_ready_after_b", req_ready, 1);
      @(negedge clk);
      #1 chk("wr_done_pulse_end", wr_done, 0);
    end else begin
      forever begin
        @(negedge clk);
        axi.arready = 1'b0;
        rd_ready = (v.mode == 0) || (t % 2 == 0);
        last = (v.bad_last >= 0) ? (beat == v.bad_last) : (beat == int'(v.len));
        axi.rvalid = 1'b1; axi.rdata = rdat(n, beat); axi.rresp = v.resp;
        axi.rlast = last; axi.rid = v.id;
        #1;
        chk("rready", axi.rready, rd_ready);
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, rdat(n, beat));
        chk("rd_resp", rd_resp, v.resp);
        chk("rd_last", rd_last, last);
        chk("err_tmo_in_r", err_tmo, exp_tmo);
        t++;
        if (rd_ready) begin
          if (last) break;
          beat++;
        end
      end
      @(negedge clk);
      axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_ready = 1'b0;
      #1;
      chk("req_ready_after_r", req_ready, 1);
      chk("rd_valid_idle", rd_valid, 0);
    end
    chk("err_len", err_len, v.exp_err_len);
    chk("err_tmo", err_tmo, exp_tmo);
    $display("txn %0d %s addr=%08h len=%0d beats=%0d resp=%0d err_len=%0b err_tmo=%0b",
             n, v.we ? "WR" : "RD", v.addr, v.len, beat + 1, v.resp, err_len, err_tmo);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_1004,  4'd3, 4'h2, 0,  0, AXI_RESP_OKAY,   0, -1, 32'h0000_1000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_2000,  4'd0, 4'h5, 5,  0, AXI_RESP_OKAY,   0, -1, 32'h0000_2000, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_3010,  4'd7, 4'h1, 1,  0, AXI_RESP_SLVERR, 1, -1, 32'h0000_3010, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0040,  4'd1, 4'h7, 0,  3, AXI_RESP_SLVERR, 1, -1, 32'h0000_0040, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_5008,  4'd3, 4'h3, 0,  0, AXI_RESP_OKAY,   0,  1, 32'h0000_5008, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_600F,  4'd1, 4'h9, 0,  0, AXI_RESP_DECERR, 1, -1, 32'h0000_6008, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_7F80, 4'd15, 4'hF, 2,  1, AXI_RESP_OKAY,   0, -1, 32'h0000_7F80, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_8000,  4'd0, 4'h4, 0, 20, AXI_RESP_OKAY,   0, -1, 32'h0000_8000, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_9100,  4'd1, 4'h6, 0,  0, AXI_RESP_DECERR, 0, -1, 32'h0000_9100, 1'b0};

    idle_slave();
    #7;
    chk_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("req_ready_post_reset", req_ready, 1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset lands mid-write after two of four beats; flags set earlier must clear too.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_A000; req_len = 4'd3; req_id = 4'hA;
    @(negedge clk);
    req_valid = 1'b0; axi.awready = 1'b1;
    #1 chk("rstseq_awvalid", axi.awvalid, 1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      axi.awready = 1'b0; axi.wready = 1'b1; wd_valid = 1'b1; wd_data = wdat(99, b);
      #1;
      chk("rstseq_wvalid", axi.wvalid, 1);
      chk("rstseq_wlast", axi.wlast, 0);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rstseq_wvalid_async", axi.wvalid, 0);
    chk("rstseq_wd_ready_async", wd_ready, 0);
    chk("rstseq_wdata_async", axi.wdata, 0);
    chk("rstseq_err_len_async", err_len, 0);
    chk("rstseq_err_tmo_async", err_tmo, 0);
    chk("rstseq_req_ready_async", req_ready, 1);
    @(negedge clk);
    wd_valid = 1'b0;
    idle_slave();
    rst_n = 1'b1;
    exp_tmo = 1'b0;
    #1 chk_quiet("post_rst");
    $display("txn R reset mid-write after 2 of 4 beats, req_ready=%0b err_len=%0b err_tmo=%0b",
             req_ready, err_len, err_tmo);

    run_vec(8, vecs[8]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
